uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side buffer that sits directly upstream of the `uart` peripheral's transmitter. Accepts bytes from system logic at up to one per clock, stores them in a circular FIFO, and drains them into the uart one at a time over the `tx_data` / `tx_wr` / `tx_busy` handshake. Producers never watch `tx_busy`; they only watch `full`.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2**DEPTH_LOG2 entries (16).
- `GUARD`, 4: maximum cycles to wait for `tx_busy` to rise after a strobe.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue request; sampled each clock.
- `full`  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1  bytes currently stored.
- `overflow`  out  1  one-cycle pulse: write dropped because `full`.
- `tx_data`  out  8  byte presented to uart; stable while `tx_wr` is high.
- `tx_wr`  out  1  one-cycle write strobe to uart.
- `tx_busy`  in  1  uart transmitter busy.

## Operation
- Storage: 2**DEPTH_LOG2 x 8 array; `wr_ptr`, `rd_ptr` are DEPTH_LOG2 bits and wrap modulo depth. `count` is a separate DEPTH_LOG2+1-bit register.
- Write: when `wr_en` is high and registered `full` is 0, store `wr_data` at `wr_ptr`, then increment `wr_ptr`. When `wr_en` is high and `full` is 1, drop the byte and pulse `overflow` for one cycle. A pop in the same cycle does not rescue the write.
- Pop: occurs only in state SEND and increments `rd_ptr`.
- `count` next value:
  - +1 on an accepted write only.
  - −1 on a pop only.
  - Unchanged when both happen or neither happens.
- `full` = (count == 2**DEPTH_LOG2); `empty` = (count == 0). Both are derived from registered `count`.
- FSM states:
  - IDLE: if `!empty && !tx_busy`, load `tx_data <= mem[rd_ptr]` and go to SEND; otherwise stay.
  - SEND: `tx_wr = 1`, pop, go to WAIT_HI, clear the guard counter.
  - WAIT_HI: if `tx_busy`, go to WAIT_LO. Otherwise increment the guard counter; when it reaches GUARD−1, go to IDLE. This guard prevents a deadlock if the uart never asserts busy.
  - WAIT_LO: when `!tx_busy`, go to IDLE.
- `tx_wr` is high only in SEND, so it is exactly one cycle per byte.
- `tx_data` is held until the next load, never cleared between bytes.
- Reset (asynchronous, at any point):
  - Pointers, `count` and guard counter go to 0. State goes to IDLE.
  - Outputs: `tx_data` = 8'h00, `tx_wr` = 0, `overflow` = 0, `empty` = 1, `full` = 0, `count` = 0.
  - A byte mid-strobe is lost. Memory contents are not cleared.

## Timing
- Write latency: a write at edge N is visible in `count`, `empty` and `full` after edge N.
- First byte from empty, with uart idle: write at edge 0; IDLE loads `tx_data` at edge 1; `tx_wr` high during cycle 2 (edge 1 → edge 2). Minimum latency is 2 cycles from write to strobe.
- Byte-to-byte spacing:
  - At least 3 cycles (SEND, WAIT_HI, IDLE) plus the uart busy time.
  - The guard path takes at most GUARD+2 cycles per byte.
- Simultaneous write and pop at `count` == 2**DEPTH_LOG2 − 1 is legal: `count` is unchanged.
- Simultaneous write and pop at `count` == 1 is legal: `count` stays 1 and `empty` never rises.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding: `TXF_IDLE`=2'd0, `TXF_SEND`=2'd1, `TXF_WAIT_HI`=2'd2, `TXF_WAIT_LO`=2'd3;
  - default `GUARD`;
  - byte width constant 8.
- Sub-module `uart_fifo_mem`: storage array, both pointers and `count`, with `push`/`pop` inputs and `full`/`empty` outputs.
- The top of `uart_tx_fifo` holds the drain FSM, the guard counter and the `tx_data` register.

## Test plan
- Single byte, uart model with busy asserted 1 cycle after strobe for 10 cycles: write 8'h41 → `tx_wr` for one cycle at cycle 2 with `tx_data`=8'h41, `count` returns to 0, exactly one strobe.
- Fill: 17 back-to-back writes of 0x00..0x10 with `tx_busy` held 1 → `full`=1 after 16, `overflow` pulses once on 0x10, `count`=16. Then release busy → 0x00..0x0F emitted in order, `rd_ptr` wraps, `empty`=1 at the end.
- Concurrent write and pop: `count`=15, write in the same cycle as SEND → `count` stays 15, `full` stays 0; repeat at `count`=1 → `empty` stays 0.
- Guard: uart model never asserts `tx_busy`, 3 bytes queued → strobes spaced GUARD+2 = 6 cycles apart, all 3 bytes emitted.
- Async reset asserted during SEND with `count`=5 → same cycle `tx_wr`=0, `count`=0, `empty`=1. After release, a write of 8'h55 is the next byte emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit path: byte width, guard default
// and the drain FSM state encoding.
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int GUARD_DEFAULT = 4;

  typedef enum logic [1:0] {
    TXF_IDLE    = 2'd0,
    TXF_SEND    = 2'd1,
    TXF_WAIT_HI = 2'd2,
    TXF_WAIT_LO = 2'd3
  } txf_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side and uart-side handshake bundle for uart_tx_fifo.
// The slave modport is the FIFO. The master modport drives writes and models the uart.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) ();

  logic [BYTE_W-1:0]   wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic [BYTE_W-1:0]   tx_data;
  logic                tx_wr;
  logic                tx_busy;

  modport master (
    output wr_data, wr_en, tx_busy,
    input  full, empty, count, overflow, tx_data, tx_wr
  );

  modport slave (
    input  wr_data, wr_en, tx_busy,
    output full, empty, count, overflow, tx_data, tx_wr
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Circular byte store with wrapping pointers and a separate occupancy count.
// A write attempted while full is dropped and flagged, even if a pop happens that cycle.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push_req,
  input  logic [BYTE_W-1:0]   i_wr_data,
  input  logic                i_pop,
  output logic [BYTE_W-1:0]   o_rd_data,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_overflow,
  output logic [DEPTH_LOG2:0] o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [BYTE_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;

  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push_req && !o_full;
  assign o_overflow = i_push_req && o_full;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the uart: queues bytes and strobes them out one at a time.
// A guard counter stops the drain FSM from stalling if the uart never reports busy.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int GUARD      = GUARD_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam int GUARD_W = $clog2(GUARD) + 1;

  txf_state_e          r_state;
  txf_state_e          w_next_state;
  logic [GUARD_W-1:0]  r_guard;
  logic [GUARD_W-1:0]  w_guard_next;
  logic [BYTE_W-1:0]   r_tx_data;
  logic [BYTE_W-1:0]   w_rd_data;
  logic                w_load;
  logic                w_pop;
  logic                w_empty;

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk        (clk),
    .reset      (reset),
    .i_push_req (bus.wr_en),
    .i_wr_data  (bus.wr_data),
    .i_pop      (w_pop),
    .o_rd_data  (w_rd_data),
    .o_full     (bus.full),
    .o_empty    (w_empty),
    .o_overflow (bus.overflow),
    .o_count    (bus.count)
  );

  assign bus.empty   = w_empty;
  assign bus.tx_data = r_tx_data;
  assign bus.tx_wr   = w_pop;

  always_comb begin
    w_next_state = r_state;
    w_guard_next = r_guard;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      TXF_IDLE: begin
        if (!w_empty && !bus.tx_busy) begin
          w_load       = 1'b1;
          w_next_state = TXF_SEND;
        end
      end
      TXF_SEND: begin
        w_pop        = 1'b1;
        w_guard_next = '0;
        w_next_state = TXF_WAIT_HI;
      end
      TXF_WAIT_HI: begin
        if (bus.tx_busy) begin
          w_next_state = TXF_WAIT_LO;
        end else begin
          w_guard_next = r_guard + 1'b1;
          if (r_guard == GUARD_W'(GUARD - 1)) begin
            w_next_state = TXF_IDLE;
          end
        end
      end
      TXF_WAIT_LO: begin
        if (!bus.tx_busy) begin
          w_next_state = TXF_IDLE;
        end
      end
      default: w_next_state = TXF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= TXF_IDLE;
      r_guard   <= '0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_next_state;
      r_guard <= w_guard_next;
      if (w_load) begin
        r_tx_data <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small uart model drives tx_busy and a
// scoreboard queue of accepted bytes is checked against every tx_wr strobe.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH_LOG2 = 4;
  localparam int GUARD      = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef enum int {UART_NORMAL, UART_HOLD, UART_NEVER} uart_mode_e;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         strobeCount = 0;
  int         busyLeft = 0;
  bit         pendingRise = 1'b0;
  int         s0;
  logic       lastOverflow;
  logic [7:0] expByte;
  uart_mode_e uartMode = UART_NORMAL;
  logic [7:0] expQ[$];
  int         strobeCyc[$];

  uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .GUARD      (GUARD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Strobe monitor plus uart model: busy rises one cycle after a strobe and lasts 10 cycles.
  always @(negedge clk) begin
    if (!reset && bus.tx_wr === 1'b1) begin
      strobeCount++;
      strobeCyc.push_back(cyc);
      checkOutput("strobe_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        expByte = expQ.pop_front();
        checkOutput("strobe_data", {24'd0, bus.tx_data}, {24'd0, expByte});
      end
    end
    case (uartMode)
      UART_HOLD: begin
        bus.tx_busy = 1'b1;
        busyLeft    = 0;
        pendingRise = 1'b0;
      end
      UART_NEVER: begin
        bus.tx_busy = 1'b0;
        busyLeft    = 0;
        pendingRise = 1'b0;
      end
      default: begin
        if (pendingRise) begin
          pendingRise = 1'b0;
          busyLeft    = 10;
        end
        if (busyLeft > 0) begin
          bus.tx_busy = 1'b1;
          busyLeft--;
        end else begin
          bus.tx_busy = 1'b0;
        end
        if (bus.tx_wr === 1'b1) pendingRise = 1'b1;
      end
    endcase
  end

  // One write cycle; call at posedge+1, returns at the next posedge+1.
  task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
    @(negedge clk);
    lastOverflow = bus.overflow;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    if (expectAccept) expQ.push_back(data);
    checkOutput("overflow_pulse", 32'(lastOverflow), 32'(!expectAccept));
  endtask

  task automatic waitStrobe(input string tag, input int budget);
    int i = 0;
    while (bus.tx_wr !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    checkOutput(tag, 32'(bus.tx_wr), 32'd1);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int i = 0;
    while (expQ.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
    repeat (15) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_count", 32'(bus.count), 32'd0);
    checkOutput("reset_empty", 32'(bus.empty), 32'd1);
    checkOutput("reset_full", 32'(bus.full), 32'd0);
    checkOutput("reset_tx_wr", 32'(bus.tx_wr), 32'd0);
    checkOutput("reset_tx_data", 32'(bus.tx_data), 32'h00);
    checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);

    // Single byte with a well-behaved uart.
    @(posedge clk); #1;
    s0 = strobeCount;
    applyStimulus(8'h41, 1'b1);
    @(negedge clk);
    checkOutput("t1_no_early_strobe", 32'(bus.tx_wr), 32'd0);
    checkOutput("t1_count_after_write", 32'(bus.count), 32'd1);
    checkOutput("t1_not_empty", 32'(bus.empty), 32'd0);
    @(negedge clk);
    checkOutput("t1_strobe_cycle2", 32'(bus.tx_wr), 32'd1);
    checkOutput("t1_tx_data", 32'(bus.tx_data), 32'h41);
    @(negedge clk);
    checkOutput("t1_strobe_one_cycle", 32'(bus.tx_wr), 32'd0);
    checkOutput("t1_count_zero", 32'(bus.count), 32'd0);
    waitDrain("t1_drain", 50);
    checkOutput("t1_strobe_total", 32'(strobeCount - s0), 32'd1);
    checkOutput("t1_empty_end", 32'(bus.empty), 32'd1);

    // Fill past capacity while the uart is held busy.
    uartMode = UART_HOLD;
    @(negedge clk);
    @(posedge clk); #1;
    s0 = strobeCount;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'(i), i < DEPTH);
    @(negedge clk);
    checkOutput("t2_count_full", 32'(bus.count), 32'd16);
    checkOutput("t2_full", 32'(bus.full), 32'd1);
    checkOutput("t2_no_strobe_while_busy", 32'(strobeCount - s0), 32'd0);
    uartMode = UART_NORMAL;
    waitDrain("t2_drain", 400);
    checkOutput("t2_strobe_total", 32'(strobeCount - s0), 32'd16);
    checkOutput("t2_empty_end", 32'(bus.empty), 32'd1);
    checkOutput("t2_count_end", 32'(bus.count), 32'd0);

    // Write coinciding with a pop at count 15.
    uartMode = UART_HOLD;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(8'(8'h60 + i), 1'b1);
    @(negedge clk);
    checkOutput("t3_count15", 32'(bus.count), 32'd15);
    uartMode = UART_NORMAL;
    waitStrobe("t3_strobe_seen", 20);
    checkOutput("t3_count_in_send", 32'(bus.count), 32'd15);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    expQ.push_back(8'h77);
    @(negedge clk);
    checkOutput("t3_count_stays15", 32'(bus.count), 32'd15);
    checkOutput("t3_full_stays0", 32'(bus.full), 32'd0);
    waitDrain("t3_drain", 400);

    // Write coinciding with a pop at count 1.
    uartMode = UART_HOLD;
    @(negedge clk);
    @(posedge clk); #1;
    applyStimulus(8'h31, 1'b1);
    @(negedge clk);
    uartMode = UART_NORMAL;
    waitStrobe("t3b_strobe_seen", 20);
    checkOutput("t3b_count_in_send", 32'(bus.count), 32'd1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h32;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    expQ.push_back(8'h32);
    @(negedge clk);
    checkOutput("t3b_count_stays1", 32'(bus.count), 32'd1);
    checkOutput("t3b_empty_stays0", 32'(bus.empty), 32'd0);
    waitDrain("t3b_drain", 100);
    checkOutput("t3b_empty_end", 32'(bus.empty), 32'd1);

    // Uart that never raises busy: the guard paces the strobes.
    uartMode = UART_NEVER;
    @(negedge clk);
    @(posedge clk); #1;
    strobeCyc.delete();
    s0 = strobeCount;
    applyStimulus(8'hA1, 1'b1);
    applyStimulus(8'hA2, 1'b1);
    applyStimulus(8'hA3, 1'b1);
    waitDrain("t4_drain", 100);
    checkOutput("t4_strobe_total", 32'(strobeCount - s0), 32'd3);
    if (strobeCyc.size() >= 3) begin
      checkOutput("t4_spacing_1_2", 32'(strobeCyc[1] - strobeCyc[0]), 32'(GUARD + 2));
      checkOutput("t4_spacing_2_3", 32'(strobeCyc[2] - strobeCyc[1]), 32'(GUARD + 2));
    end

    // Asynchronous reset in the middle of a strobe.
    uartMode = UART_HOLD;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'hB0 + i), 1'b1);
    @(negedge clk);
    checkOutput("t5_count5", 32'(bus.count), 32'd5);
    uartMode = UART_NORMAL;
    waitStrobe("t5_strobe_seen", 20);
    checkOutput("t5_count_in_send", 32'(bus.count), 32'd5);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_tx_wr", 32'(bus.tx_wr), 32'd0);
    checkOutput("t5_rst_count", 32'(bus.count), 32'd0);
    checkOutput("t5_rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("t5_rst_full", 32'(bus.full), 32'd0);
    checkOutput("t5_rst_tx_data", 32'(bus.tx_data), 32'h00);
    expQ.delete();
    s0 = strobeCount;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'h55, 1'b1);
    waitDrain("t5_drain", 100);
    checkOutput("t5_strobe_total", 32'(strobeCount - s0), 32'd1);
    checkOutput("t5_empty_end", 32'(bus.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
